jtag_dbg_bus_dr: RTL and testbench

//  Debug data register behind the JTAG TAP controller, selected by instruction DEBUG (4'b1000).

---
 rtl/jtag_dbg_bus_dr_pkg.sv | 27 ++
 rtl/jtag_dbg_bus_dr.sv | 170 +++++++++++++++++
 tb/tb_jtag_dbg_bus_dr.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dbg_bus_dr_pkg.sv
// Shared definitions for the JTAG debug bus data register: instruction opcode,
// status bit positions, DR field offsets and the access FSM encoding.
package jtag_dbg_bus_dr_pkg;

  localparam logic [3:0] DEBUG_OPCODE = 4'b1000;

  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_OVR  = 2;

  localparam int DR_WE_BIT   = 0;
  localparam int DR_ADDR_LSB = 1;

  function automatic int dr_wdata_lsb(input int aw);
    return aw + 1;
  endfunction

  function automatic int dr_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/jtag_dbg_bus_dr.sv
// Debug data register behind the TAP: shifts in a bus command, launches one
// req/ack access with timeout on Update-DR, and captures read data plus status.
module jtag_dbg_bus_dr
  import jtag_dbg_bus_dr_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          tck_i,
  input  logic          trst_n_i,
  input  logic          debug_select_i,
  input  logic          capture_dr_i,
  input  logic          shift_dr_i,
  input  logic          update_dr_i,
  input  logic          tdi_i,
  output logic          debug_tdo_o,
  output logic          busy_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic          bus_ack_i,
  input  logic          bus_err_i,
  input  logic [DW-1:0] bus_rdata_i
);

  localparam int DR_W     = dr_width(AW, DW);
  localparam int WD_LSB   = dr_wdata_lsb(AW);
  localparam int CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  dbg_state_e      r_state;
  dbg_state_e      w_state_nxt;
  logic [DR_W-1:0] r_sr;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic            r_ovr;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [CW-1:0]   r_cnt;
  logic            r_tdo;

  logic w_capture;
  logic w_shift;
  logic w_update;
  logic w_in_req;
  logic w_ack;
  logic w_timeout;
  logic w_launch;
  logic w_done;
  logic w_err_set;
  logic w_ovr_set;

  // Status occupies the low bits, read data the same field as write data.
  function automatic logic [DR_W-1:0] f_capture_word(
    input logic          busy,
    input logic          err,
    input logic          ovr,
    input logic [DW-1:0] rdata
  );
    logic [DR_W-1:0] word;
    word              = '0;
    word[STAT_BUSY]   = busy;
    word[STAT_ERR]    = err;
    word[STAT_OVR]    = ovr;
    word[DR_W-1:WD_LSB] = rdata;
    return word;
  endfunction

  assign w_capture = debug_select_i & capture_dr_i;
  assign w_shift   = debug_select_i & shift_dr_i;
  assign w_update  = debug_select_i & update_dr_i;

  assign w_in_req  = (r_state == ST_REQ);
  assign w_ack     = w_in_req & bus_ack_i;
  // Ack on the last counted cycle takes precedence over the timeout.
  assign w_timeout = w_in_req & ~bus_ack_i & (r_cnt == CNT_LAST);
  assign w_done    = w_ack | w_timeout;
  assign w_launch  = w_update & ~w_in_req;
  assign w_ovr_set = w_update & w_in_req;
  assign w_err_set = (w_ack & bus_err_i) | w_timeout;

  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_REQ;
      ST_REQ:  if (w_done)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      r_sr <= '0;
    end else if (w_capture) begin
      r_sr <= f_capture_word(w_in_req, r_err, r_ovr, r_rdata);
    end else if (w_shift) begin
      r_sr <= {tdi_i, r_sr[DR_W-1:1]};
    end
  end

  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_launch) begin
      r_we    <= r_sr[DR_WE_BIT];
      r_addr  <= r_sr[AW:DR_ADDR_LSB];
      r_wdata <= r_sr[DR_W-1:WD_LSB];
    end
  end

  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      r_cnt <= '0;
    end else if (w_launch || w_done) begin
      r_cnt <= '0;
    end else if (w_in_req) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Sticky flags: a set event on a capture edge survives the read-to-clear.
  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      r_err <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_err_set)      r_err <= 1'b1;
      else if (w_capture) r_err <= 1'b0;
      if (w_ovr_set)      r_ovr <= 1'b1;
      else if (w_capture) r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      r_rdata <= '0;
    end else if (w_ack && !r_we) begin
      r_rdata <= bus_rdata_i;
    end
  end

  always_ff @(negedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      r_tdo <= 1'b0;
    end else begin
      r_tdo <= r_sr[0];
    end
  end

  assign debug_tdo_o = r_tdo;
  assign busy_o      = w_in_req;
  assign bus_req_o   = w_in_req;
  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;

endmodule

// File: tb/tb_jtag_dbg_bus_dr.sv
// Randomized and directed bench for jtag_dbg_bus_dr against a transaction-level model.
module tb_jtag_dbg_bus_dr;
  import jtag_dbg_bus_dr_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 100;

  logic          tck_i = 1'b0;
  logic          trst_n_i;
  logic          debug_select_i;
  logic          capture_dr_i;
  logic          shift_dr_i;
  logic          update_dr_i;
  logic          tdi_i;
  logic          debug_tdo_o;
  logic          busy_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic          bus_ack_i;
  logic          bus_err_i;
  logic [DW-1:0] bus_rdata_i;

  logic [3:0] ir;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [64:0]   m_sr;
  logic          m_busy;
  int            m_age;
  logic          m_err, m_ovr, m_tdo;
  logic [DW-1:0] m_rdata;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  jtag_dbg_bus_dr #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
    .tck_i(tck_i), .trst_n_i(trst_n_i), .debug_select_i(debug_select_i),
    .capture_dr_i(capture_dr_i), .shift_dr_i(shift_dr_i), .update_dr_i(update_dr_i),
    .tdi_i(tdi_i), .debug_tdo_o(debug_tdo_o), .busy_o(busy_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 tck_i = ~tck_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_sr = '0; m_busy = 0; m_age = 0; m_err = 0; m_ovr = 0; m_tdo = 0;
    m_rdata = '0; m_we = 0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".req"},   bus_req_o,   m_busy);
    chk({tag, ".busy"},  busy_o,      m_busy);
    chk({tag, ".we"},    bus_we_o,    m_we);
    chk({tag, ".addr"},  bus_addr_o,  m_addr);
    chk({tag, ".wdata"}, bus_wdata_o, m_wdata);
    chk({tag, ".tdo"},   debug_tdo_o, m_tdo);
  endtask

  // Advance one TCK edge: evolve the model from the currently driven inputs, then compare.
  task automatic tick(input string tag);
    logic sel, cap, sh, up, fin_ack, fin_to;
    logic [64:0] cw;
    logic n_err, n_ovr;
    sel = (ir == DEBUG_OPCODE) && debug_select_i;
    cap = sel && capture_dr_i;
    sh  = sel && shift_dr_i;
    up  = sel && update_dr_i;
    m_tdo   = m_sr[0];
    cw      = {m_rdata, 30'b0, m_ovr, m_err, m_busy};
    fin_ack = m_busy && bus_ack_i;
    fin_to  = m_busy && !bus_ack_i && (m_age + 1 == T);
    n_err = cap ? 1'b0 : m_err;
    if ((fin_ack && bus_err_i) || fin_to) n_err = 1'b1;
    n_ovr = cap ? 1'b0 : m_ovr;
    if (up && m_busy) n_ovr = 1'b1;
    if (fin_ack && !m_we) m_rdata = bus_rdata_i;
    if (m_busy) begin
      if (fin_ack || fin_to) m_busy = 0;
      else m_age++;
    end else if (up) begin
      m_we = m_sr[0]; m_addr = m_sr[32:1]; m_wdata = m_sr[64:33];
      m_busy = 1; m_age = 0;
    end
    if (cap) m_sr = cw;
    else if (sh) m_sr = {tdi_i, m_sr[64:1]};
    m_err = n_err; m_ovr = n_ovr;
    @(posedge tck_i);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    capture_dr_i = 0; shift_dr_i = 0; update_dr_i = 0; tdi_i = 0;
    bus_ack_i = 0; bus_err_i = 0;
  endtask

  task automatic do_idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) tick("idle");
  endtask

  task automatic do_shift(input logic [64:0] din, output logic [64:0] dout);
    idle_inputs();
    shift_dr_i = 1;
    for (int i = 0; i < 65; i++) begin
      tdi_i = din[i];
      tick("shift");
      dout[i] = debug_tdo_o;
    end
    idle_inputs();
  endtask

  task automatic do_capture();
    idle_inputs(); capture_dr_i = 1; tick("capture"); idle_inputs();
  endtask

  task automatic do_update();
    idle_inputs(); update_dr_i = 1; tick("update"); idle_inputs();
  endtask

  task automatic do_ack(input logic err, input logic [DW-1:0] rd);
    idle_inputs(); bus_ack_i = 1; bus_err_i = err; bus_rdata_i = rd;
    tick("ack"); idle_inputs();
  endtask

  task automatic read_status(output logic [64:0] word);
    do_capture();
    do_shift(65'h0, word);
  endtask

  initial begin
    logic [64:0] dout, word, keep;
    int n;
    ir = DEBUG_OPCODE;
    debug_select_i = 1;
    bus_rdata_i = '0;
    idle_inputs();
    trst_n_i = 0;
    m_reset();
    #1;
    chk("rst.req", bus_req_o, 1'b0);
    chk("rst.busy", busy_o, 1'b0);
    chk("rst.tdo", debug_tdo_o, 1'b0);
    chk("rst.addr", bus_addr_o, 32'h0);
    @(posedge tck_i); @(posedge tck_i); #1;
    trst_n_i = 1;

    // 1: write command
    do_shift({32'hDEADBEEF, 32'h100, 1'b1}, dout);
    do_update();
    chk("t1.req", bus_req_o, 1'b1);
    chk("t1.we", bus_we_o, 1'b1);
    chk("t1.addr", bus_addr_o, 32'h100);
    chk("t1.wdata", bus_wdata_o, 32'hDEADBEEF);
    do_idle(2);
    do_ack(1'b0, 32'hFFFF_FFFF);
    chk("t1.req_low", bus_req_o, 1'b0);
    chk("t1.busy_low", busy_o, 1'b0);

    // 2: read command and status shift-out
    do_shift({32'h0, 32'h200, 1'b0}, dout);
    do_update();
    chk("t2.addr", bus_addr_o, 32'h200);
    do_idle(2);
    do_ack(1'b0, 32'h12345678);
    read_status(word);
    chk("t2.stream", word, {32'h12345678, 30'b0, 3'b000});

    // 3: read with no ack times out after exactly T cycles
    do_shift({32'h0, 32'h300, 1'b0}, dout);
    do_update();
    n = 1;
    for (int i = 0; i < T + 10 && bus_req_o; i++) begin
      tick("t3.wait");
      if (bus_req_o) n++;
    end
    chk("t3.req_cycles", n, T);
    read_status(word);
    chk("t3.err_set", word[2:0], 3'b010);
    chk("t3.rdata_kept", word[64:33], 32'h12345678);
    read_status(word);
    chk("t3.err_clr", word[2:0], 3'b000);

    // 4: update while busy is dropped and flagged
    do_shift({32'hA5A5_0001, 32'h400, 1'b1}, dout);
    do_update();
    do_shift({32'h0BAD_0BAD, 32'h999, 1'b0}, dout);
    do_update();
    chk("t4.addr_kept", bus_addr_o, 32'h400);
    chk("t4.wdata_kept", bus_wdata_o, 32'hA5A5_0001);
    chk("t4.we_kept", bus_we_o, 1'b1);
    do_ack(1'b0, 32'h5555_5555);
    read_status(word);
    chk("t4.ovr", word[2:0], 3'b100);
    chk("t4.wr_no_rdata", word[64:33], 32'h12345678);
    // ack and timeout on the same edge, err=0 then err=1
    for (int e = 0; e < 2; e++) begin
      do_shift({32'h0, 32'h500 + e, 1'b0}, dout);
      do_update();
      do_idle(T - 1);
      chk("t4.still_req", bus_req_o, 1'b1);
      do_ack(e[0], 32'hC0DE_0000 + e);
      chk("t4.done", bus_req_o, 1'b0);
      read_status(word);
      chk("t4.race_err", word[1], e[0]);
      chk("t4.race_rdata", word[64:33], 32'hC0DE_0000 + e);
    end

    // 5: async reset in the middle of a request
    do_shift({32'h1111_2222, 32'h600, 1'b1}, dout);
    do_update();
    do_idle(2);
    chk("t5.pre_tdo", debug_tdo_o, 1'b1);
    #2 trst_n_i = 0;
    #1;
    chk("t5.req", bus_req_o, 1'b0);
    chk("t5.busy", busy_o, 1'b0);
    chk("t5.tdo", debug_tdo_o, 1'b0);
    m_reset();
    @(posedge tck_i); #1;
    trst_n_i = 1;
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      bus_ack_i = i[0];
      tick("t5.post");
    end
    chk("t5.no_req", bus_req_o, 1'b0);

    // 6: deselected shift/update/capture leave the register alone
    keep = {32'hFACE_B00C, 32'h700, 1'b1};
    do_shift(keep, dout);
    debug_select_i = 0;
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      case (i % 4)
        0: shift_dr_i = 1;
        1: update_dr_i = 1;
        2: capture_dr_i = 1;
        default: ;
      endcase
      tdi_i = ~keep[i];
      tick("t6.desel");
    end
    chk("t6.no_req", bus_req_o, 1'b0);
    debug_select_i = 1;
    do_shift(65'h0, dout);
    chk("t6.sr_held", dout, keep);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      int op;
      idle_inputs();
      op = $urandom_range(0, 9);
      debug_select_i = ($urandom_range(0, 7) != 0);
      tdi_i = $urandom_range(0, 1);
      if (op <= 3) shift_dr_i = 1;
      else if (op == 4) capture_dr_i = 1;
      else if (op == 5) update_dr_i = 1;
      bus_ack_i   = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      bus_err_i   = $urandom_range(0, 1);
      bus_rdata_i = $urandom;
      tick("rnd");
    end
    debug_select_i = 1;
    read_status(word);
    chk("rnd.final_status", word, dout ^ dout ^ {m_rdata, 30'b0, 3'b000} | word[2:0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
